// File: rtl/uart_pkg.sv
// Shared encodings, FSM states and helpers for the UART receive path.
package uart_pkg;

  localparam logic [1:0] DB_5 = 2'b00;
  localparam logic [1:0] DB_6 = 2'b01;
  localparam logic [1:0] DB_7 = 2'b10;
  localparam logic [1:0] DB_8 = 2'b11;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int PAR_ERR = 1;
  localparam int FRM_ERR = 0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  function automatic logic maj3(input logic a, input logic b,
                                input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [2:0] last_idx(input logic [1:0] db);
    logic [2:0] r;
    r = 3'd7;
    unique case (db)
      DB_5: r = 3'd4;
      DB_6: r = 3'd5;
      DB_7: r = 3'd6;
      DB_8: r = 3'd7;
      default: r = 3'd7;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; a write on full is accepted
// only when a read frees a slot in the same cycle, otherwise it is dropped.
module sync_fifo #(
  parameter int W  = 10,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  input  logic         rd,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full,
  output logic         drop
);

  localparam int D = 1 << AW;

  logic [W-1:0] mem [D];
  logic [AW:0]  wp;
  logic [AW:0]  rp;
  logic         do_wr;
  logic         do_rd;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);
  assign drop  = wr && !do_wr;
  assign rdata = empty ? '0 : mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wp[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_path.sv
// UART receive path: synchroniser, baud tick generator, framing FSM with
// parity/stop options, and an error-tagged FWFT receive FIFO.
module uart_rx_path
  import uart_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int S_TICK  = 16,
  parameter int DIV_W   = 16,
  parameter int FIFO_W  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx,
  input  logic [DIV_W-1:0]   divisor,
  input  logic [1:0]         data_bits,
  input  logic [1:0]         parity_mode,
  input  logic               stop_bits,
  input  logic               rd,
  input  logic               clr_overrun,
  output logic [NB_DATA-1:0] r_data,
  output logic [1:0]         r_err,
  output logic               empty,
  output logic               full,
  output logic               overrun,
  output logic               busy
);

  localparam int SW = $clog2(S_TICK);
  localparam logic [SW-1:0] T_S0  = SW'(S_TICK/2 - 1);
  localparam logic [SW-1:0] T_S1  = SW'(S_TICK/2);
  localparam logic [SW-1:0] T_S2  = SW'(S_TICK/2 + 1);
  localparam logic [SW-1:0] T_END = SW'(S_TICK - 1);

  logic [1:0]         sync;
  logic               rs;
  logic [DIV_W-1:0]   cnt;
  logic               tick;
  rx_state_t          state;
  rx_state_t          state_n;
  logic [SW-1:0]      s_cnt;
  logic [2:0]         n_cnt;
  logic               stop_n;
  logic [7:0]         sr;
  logic               s0;
  logic               s1;
  logic               frm_q;
  logic               par_q;
  logic               armed;
  logic [1:0]         cfg_db;
  logic [1:0]         cfg_par;
  logic               cfg_stop;
  logic               start_det;
  logic               at_vote;
  logic               at_end;
  logic               vote;
  logic               last_bit;
  logic               last_stop;
  logic               par_en;
  logic               push;
  logic               drop;
  logic [NB_DATA+1:0] wdata;
  logic [NB_DATA+1:0] fdata;

  assign rs = sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= 2'b11;
    else       sync <= {sync[0], rx};
  end

  // Compare with >= so a shrinking divisor never lets cnt run past it.
  assign tick = (cnt >= divisor);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

  // The line must be seen high before a new start is accepted, so a
  // break produces one framing-error word instead of a stream of them.
  assign start_det = (state == IDLE) && !rs && armed;
  assign at_vote   = tick && (s_cnt == T_S2);
  assign at_end    = tick && (s_cnt == T_END);
  assign vote      = maj3(s0, s1, rs);
  assign last_bit  = (n_cnt == last_idx(cfg_db));
  assign last_stop = !cfg_stop || stop_n;
  assign par_en    = (cfg_par == PAR_EVEN) ||
                     (cfg_par == PAR_ODD);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    push    = 1'b0;
    unique case (state)
      IDLE:   if (start_det) state_n = START;
      START: begin
        if (at_vote && vote) state_n = IDLE;
        else if (at_end)     state_n = DATA;
      end
      DATA: begin
        if (at_end && last_bit)
          state_n = par_en ? PARITY : STOP;
      end
      PARITY: if (at_end) state_n = STOP;
      STOP: begin
        if (at_vote && last_stop) begin
          push    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_cnt    <= '0;
      n_cnt    <= '0;
      stop_n   <= 1'b0;
      sr       <= '0;
      s0       <= 1'b1;
      s1       <= 1'b1;
      frm_q    <= 1'b0;
      par_q    <= 1'b0;
      armed    <= 1'b1;
      cfg_db   <= DB_8;
      cfg_par  <= PAR_NONE;
      cfg_stop <= 1'b0;
    end else begin
      if (rs) armed <= 1'b1;
      if (start_det) begin
        armed    <= 1'b0;
        s_cnt    <= '0;
        n_cnt    <= '0;
        stop_n   <= 1'b0;
        sr       <= '0;
        frm_q    <= 1'b0;
        par_q    <= 1'b0;
        cfg_db   <= data_bits;
        cfg_par  <= parity_mode;
        cfg_stop <= stop_bits;
      end else if (tick && state != IDLE) begin
        s_cnt <= (s_cnt == T_END) ? '0 : s_cnt + 1'b1;
        if (s_cnt == T_S0) s0 <= rs;
        if (s_cnt == T_S1) s1 <= rs;
        if (s_cnt == T_S2) begin
          unique case (state)
            DATA:   sr[n_cnt] <= vote;
            PARITY: par_q <= vote ^ (^sr) ^
                             (cfg_par == PAR_ODD);
            STOP:   if (!vote) frm_q <= 1'b1;
            default: ;
          endcase
        end
        if (s_cnt == T_END) begin
          if (state == DATA) n_cnt  <= n_cnt + 1'b1;
          if (state == STOP) stop_n <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    wdata = '0;
    wdata[NB_DATA-1:0]       = NB_DATA'(sr);
    wdata[NB_DATA + PAR_ERR] = par_q;
    wdata[NB_DATA + FRM_ERR] = frm_q | ~vote;
  end

  sync_fifo #(
    .W  (NB_DATA + 2),
    .AW (FIFO_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (push),
    .wdata (wdata),
    .rd    (rd),
    .rdata (fdata),
    .empty (empty),
    .full  (full),
    .drop  (drop)
  );

  assign r_data = fdata[NB_DATA-1:0];
  assign r_err  = {fdata[NB_DATA + PAR_ERR],
                   fdata[NB_DATA + FRM_ERR]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            overrun <= 1'b0;
    else if (drop)        overrun <= 1'b1;
    else if (clr_overrun) overrun <= 1'b0;
  end

endmodule
